// File: rtl/superh16_pkg.sv
// Shared types and default sizing for the superh16 L1 data cache MSHR.
package superh16_pkg;

  localparam int VADDR_WIDTH     = 32;
  localparam int CACHE_LINE_SIZE = 64;
  localparam int MSHR_NUM        = 4;
  localparam int LINE_TAG_W      = VADDR_WIDTH - $clog2(CACHE_LINE_SIZE);

  typedef enum logic [1:0] {
    MSHR_FREE,
    MSHR_PEND,
    MSHR_INFLIGHT,
    MSHR_FILL
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e           state;
    logic [LINE_TAG_W-1:0] line_tag;
  } mshr_entry_t;

endpackage

// File: rtl/superh16_prio_enc.sv
// Lowest-index-first priority encoder producing both one-hot and binary grants.
module superh16_prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  assign gnt = req & (~req + N'(1));
  assign any = |req;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/superh16_dcache_mshr.sv
// MSHR controller for the L1 dcache: tracks outstanding line misses, merges
// secondary misses, issues one L2 request per line and schedules cache fills.
module superh16_dcache_mshr
  import superh16_pkg::*;
#(
  parameter int NUM_MSHR   = MSHR_NUM,
  parameter int ADDR_W     = VADDR_WIDTH,
  parameter int LINE_BYTES = CACHE_LINE_SIZE,
  parameter int IDX_W      = $clog2(NUM_MSHR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    miss_ready,
  output logic                    miss_merged,
  output logic [IDX_W-1:0]        miss_idx,
  output logic                    l2_req_valid,
  input  logic                    l2_req_ready,
  output logic [ADDR_W-1:0]       l2_req_addr,
  output logic [IDX_W-1:0]        l2_req_id,
  input  logic                    l2_resp_valid,
  input  logic [IDX_W-1:0]        l2_resp_id,
  input  logic [LINE_BYTES*8-1:0] l2_resp_data,
  output logic                    fill_valid,
  input  logic                    fill_ready,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [LINE_BYTES*8-1:0] fill_data,
  output logic [IDX_W-1:0]        fill_idx,
  input  logic                    flush_req,
  output logic                    flush_idle,
  output logic                    full
);

  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int TAG_W       = ADDR_W - OFFSET_BITS;
  localparam int DATA_W      = LINE_BYTES * 8;

  mshr_entry_t       entry_q [NUM_MSHR];
  mshr_entry_t       entry_d [NUM_MSHR];
  logic [DATA_W-1:0] data_q  [NUM_MSHR];
  logic [DATA_W-1:0] data_d  [NUM_MSHR];

  logic              l2_lock_q, l2_lock_d;
  logic [IDX_W-1:0]  l2_sel_q, l2_sel_d;
  logic              fill_lock_q, fill_lock_d;
  logic [IDX_W-1:0]  fill_sel_q, fill_sel_d;

  logic [TAG_W-1:0]    miss_tag;
  logic [NUM_MSHR-1:0] free_vec, pend_vec, fill_vec;
  logic                match_live, match_fill;
  logic [IDX_W-1:0]    match_idx;
  logic                any_free, any_pend, any_fill;
  logic [IDX_W-1:0]    alloc_idx, pend_idx, fill_pick_idx;
  logic [IDX_W-1:0]    l2_sel, fill_sel;
  logic [NUM_MSHR-1:0] unused_alloc_oh, unused_pend_oh, unused_fill_oh;
  logic                unused_offset;
  logic                do_alloc, l2_fire, fill_fire, resp_hit;

  assign miss_tag      = miss_addr[ADDR_W-1:OFFSET_BITS];
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

  // Lookup sees only registered state, so same-cycle updates never alias a match.
  always_comb begin
    free_vec   = '0;
    pend_vec   = '0;
    fill_vec   = '0;
    match_live = 1'b0;
    match_fill = 1'b0;
    match_idx  = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      free_vec[i] = (entry_q[i].state == MSHR_FREE);
      pend_vec[i] = (entry_q[i].state == MSHR_PEND);
      fill_vec[i] = (entry_q[i].state == MSHR_FILL);
      if (entry_q[i].state != MSHR_FREE &&
          entry_q[i].line_tag == LINE_TAG_W'(miss_tag)) begin
        if (entry_q[i].state == MSHR_FILL) begin
          match_fill = 1'b1;
        end else begin
          match_live = 1'b1;
          match_idx  = IDX_W'(i);
        end
      end
    end
  end

  superh16_prio_enc #(.N(NUM_MSHR), .W(IDX_W)) u_alloc_enc (
    .req (free_vec),
    .gnt (unused_alloc_oh),
    .idx (alloc_idx),
    .any (any_free)
  );

  superh16_prio_enc #(.N(NUM_MSHR), .W(IDX_W)) u_l2_enc (
    .req (pend_vec),
    .gnt (unused_pend_oh),
    .idx (pend_idx),
    .any (any_pend)
  );

  superh16_prio_enc #(.N(NUM_MSHR), .W(IDX_W)) u_fill_enc (
    .req (fill_vec),
    .gnt (unused_fill_oh),
    .idx (fill_pick_idx),
    .any (any_fill)
  );

  // A stalled request or fill keeps its entry even if a lower index becomes eligible.
  assign l2_sel   = l2_lock_q ? l2_sel_q : pend_idx;
  assign fill_sel = fill_lock_q ? fill_sel_q : fill_pick_idx;

  assign miss_ready  = miss_valid && !flush_req && !match_fill && (match_live || any_free);
  assign miss_merged = miss_ready && match_live;
  assign miss_idx    = match_live ? match_idx : alloc_idx;
  assign do_alloc    = miss_ready && !match_live;

  assign l2_req_valid = any_pend;
  assign l2_req_id    = l2_sel;
  assign l2_req_addr  = {TAG_W'(entry_q[l2_sel].line_tag), {OFFSET_BITS{1'b0}}};
  assign l2_fire      = l2_req_valid && l2_req_ready;

  assign fill_valid = any_fill;
  assign fill_idx   = fill_sel;
  assign fill_addr  = {TAG_W'(entry_q[fill_sel].line_tag), {OFFSET_BITS{1'b0}}};
  assign fill_data  = data_q[fill_sel];
  assign fill_fire  = fill_valid && fill_ready;

  assign resp_hit   = l2_resp_valid && (entry_q[l2_resp_id].state == MSHR_INFLIGHT);
  assign full       = !any_free;
  assign flush_idle = &free_vec;

  always_comb begin
    entry_d     = entry_q;
    data_d      = data_q;
    l2_lock_d   = l2_req_valid && !l2_req_ready;
    l2_sel_d    = l2_sel;
    fill_lock_d = fill_valid && !fill_ready;
    fill_sel_d  = fill_sel;
    if (do_alloc) begin
      entry_d[alloc_idx].state    = MSHR_PEND;
      entry_d[alloc_idx].line_tag = LINE_TAG_W'(miss_tag);
    end
    if (l2_fire) entry_d[l2_sel].state = MSHR_INFLIGHT;
    if (resp_hit) begin
      entry_d[l2_resp_id].state = MSHR_FILL;
      data_d[l2_resp_id]        = l2_resp_data;
    end
    if (fill_fire) entry_d[fill_sel].state = MSHR_FREE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        entry_q[i].state    <= MSHR_FREE;
        entry_q[i].line_tag <= '0;
      end
      l2_lock_q   <= 1'b0;
      l2_sel_q    <= '0;
      fill_lock_q <= 1'b0;
      fill_sel_q  <= '0;
    end else begin
      entry_q     <= entry_d;
      l2_lock_q   <= l2_lock_d;
      l2_sel_q    <= l2_sel_d;
      fill_lock_q <= fill_lock_d;
      fill_sel_q  <= fill_sel_d;
    end
  end

  // Line buffers carry no reset; an entry's data is only read once it is in FILL.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule
